// File: rtl/ct_f_spsram_wrap_init.sv
// Parametrised single-port SRAM wrapper: column-sliced fpga_ram array with a post-reset zero-fill engine.
// Optional output register stage enabled by defining CT_F_SPSRAM_OREG_EN (read latency 2 instead of 1).

module fpga_ram #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 29
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);
  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  // Write-first so the last fill write leaves zero on the port when init ends.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= din;
      dout      <= din;
    end else begin
      dout <= mem[addr];
    end
  end
endmodule

module ct_f_spsram_wrap_init #(
  parameter int ADDR_WIDTH  = 11,
  parameter int DATA_WIDTH  = 59,
  parameter int SLICE_WIDTH = 29
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [ADDR_WIDTH-1:0] A,
  input  logic                  CEN,
  input  logic                  GWEN,
  input  logic [DATA_WIDTH-1:0] D,
  input  logic [DATA_WIDTH-1:0] WEN,
  output logic [DATA_WIDTH-1:0] Q,
  output logic                  BUSY
);
  localparam int NUM_SLICES = (DATA_WIDTH + SLICE_WIDTH - 1) / SLICE_WIDTH;
  localparam int DEPTH      = 2 ** ADDR_WIDTH;

  typedef enum logic {INIT, READY} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] hold_q;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_din;
  logic [DATA_WIDTH-1:0] ram_q;
  logic [NUM_SLICES-1:0] slice_we;
  logic                  init_wr;
  logic                  user_acc;
  logic                  user_wr;
  logic                  unused_wen;

  // Handshake: BUSY is the inverse of ready; a user access (CEN=0) is only
  // accepted on cycles where BUSY=0, otherwise it is silently dropped.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= INIT;
      cnt_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (user_acc) hold_q <= A;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    init_wr  = 1'b0;
    user_acc = 1'b0;
    user_wr  = 1'b0;
    case (state_q)
      INIT: begin
        init_wr = 1'b1;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == (ADDR_WIDTH+1)'(DEPTH - 1)) state_d = READY;
      end
      READY: begin
        user_acc = !CEN;
        user_wr  = !CEN && !GWEN;
      end
      default: state_d = INIT;
    endcase
  end

  assign BUSY     = (state_q == INIT);
  assign ram_addr = init_wr ? cnt_q[ADDR_WIDTH-1:0] : (CEN ? hold_q : A);
  assign ram_din  = init_wr ? '0 : D;

  // Only each slice's top WEN bit matters; the rest are don't-care.
  assign unused_wen = ^WEN;

  for (genvar i = 0; i < NUM_SLICES; i++) begin : g_slice
    localparam int LO = i * SLICE_WIDTH;
    localparam int HI = (((i + 1) * SLICE_WIDTH < DATA_WIDTH) ? (i + 1) * SLICE_WIDTH : DATA_WIDTH) - 1;
    localparam int W  = HI - LO + 1;

    assign slice_we[i] = !RST && (init_wr || (user_wr && !WEN[HI]));

    fpga_ram #(
      .ADDR_WIDTH(ADDR_WIDTH),
      .DATA_WIDTH(W)
    ) u_ram (
      .clk  (CLK),
      .we   (slice_we[i]),
      .addr (ram_addr),
      .din  (ram_din[HI:LO]),
      .dout (ram_q[HI:LO])
    );
  end

`ifdef CT_F_SPSRAM_OREG_EN
  logic                  acc_d;
  logic [DATA_WIDTH-1:0] oreg_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      acc_d  <= 1'b0;
      oreg_q <= '0;
    end else begin
      acc_d <= user_acc;
      if (acc_d) oreg_q <= ram_q;
    end
  end

  assign Q = oreg_q;
`else
  assign Q = BUSY ? '0 : ram_q;
`endif
endmodule

// File: tb/tb_ct_f_spsram_wrap_init.sv
// Self-checking bench for ct_f_spsram_wrap_init: init fill, masking, hold, lockout, reset restart, latency, random traffic.
module tb_ct_f_spsram_wrap_init;
  localparam int AW    = 4;
  localparam int DW    = 59;
  localparam int SW    = 29;
  localparam int DEPTH = 16;
`ifdef CT_F_SPSRAM_OREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] a;
  logic          cen;
  logic          gwen;
  logic [DW-1:0] d;
  logic [DW-1:0] wen;
  logic [DW-1:0] q;
  logic          busy;

  int errors = 0;
  int checks = 0;
  logic [DW-1:0] model [DEPTH];
  logic [DW-1:0] exp_q [$];

  always #5 clk = ~clk;

  ct_f_spsram_wrap_init #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SLICE_WIDTH(SW)) dut (
    .CLK(clk), .RST(rst), .A(a), .CEN(cen), .GWEN(gwen),
    .D(d), .WEN(wen), .Q(q), .BUSY(busy)
  );

  // Reference: a bit is written when the top WEN bit of its column group is low.
  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_v, input logic [DW-1:0] new_v,
                                          input logic [DW-1:0] wmask);
    logic [DW-1:0] r;
    for (int b = 0; b < DW; b++) begin
      int top;
      top = ((b / SW) + 1) * SW;
      if (top > DW) top = DW;
      r[b] = wmask[top-1] ? old_v[b] : new_v[b];
    end
    return r;
  endfunction

  function automatic logic [DW-1:0] rand_word();
    return DW'({$urandom(), $urandom()});
  endfunction

  task automatic do_write(input logic [AW-1:0] ad, input logic [DW-1:0] dd, input logic [DW-1:0] ww);
    a = ad; d = dd; wen = ww; cen = 1'b0; gwen = 1'b0;
    @(negedge clk);
    cen = 1'b1; gwen = 1'b1;
    model[ad] = merge(model[ad], dd, ww);
  endtask

  task automatic do_read(input logic [AW-1:0] ad, output logic [DW-1:0] q_o);
    a = ad; cen = 1'b0; gwen = 1'b1;
    @(negedge clk);
    cen = 1'b1;
    repeat (LAT - 1) @(negedge clk);
    q_o = q;
  endtask

  task automatic wait_busy_low(output int n);
    n = 0;
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
  endtask

  task automatic test_reset();
    int n;
    rst = 1'b1; cen = 1'b1; gwen = 1'b1; a = '0; d = '0; wen = '1;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL reset_busy: got %b expected 1", busy); end
    checks++;
    if (q !== '0) begin errors++; $display("FAIL reset_q: got %h expected 0", q); end
    rst = 1'b0;
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
    wait_busy_low(n);
    checks++;
    if (n != DEPTH) begin errors++; $display("FAIL reset_busy_len: got %0d cycles expected %0d", n, DEPTH); end
    checks++;
    if (q !== '0) begin errors++; $display("FAIL reset_q_after_init: got %h expected 0", q); end
  endtask

  task automatic test_init_fill();
    int n;
    logic [DW-1:0] r;
    logic [DW-1:0] pat;
    pat = DW'({8{8'h5A}});
    for (int i = 0; i < DEPTH; i++) do_write(AW'(i), pat, '0);
    do_read(4'd9, r);
    checks++;
    if (r !== pat) begin errors++; $display("FAIL fill_preload: got %h expected %h", r, pat); end
    pulse_reset();
    wait_busy_low(n);
    checks++;
    if (n != DEPTH) begin errors++; $display("FAIL fill_busy_len: got %0d expected %0d", n, DEPTH); end
    for (int i = 0; i < DEPTH; i++) begin
      do_read(AW'(i), r);
      checks++;
      if (r !== '0) begin errors++; $display("FAIL fill_zero[%0d]: got %h expected 0", i, r); end
    end
  endtask

  task automatic test_slice_mask();
    logic [DW-1:0] r;
    logic [DW-1:0] ww;
    ww = '1; ww[28] = 1'b0;
    do_write(4'd3, '1, ww);
    do_read(4'd3, r);
    checks++;
    if (r !== 59'h1FFFFFFF) begin errors++; $display("FAIL mask_slice0: got %h expected 1fffffff", r); end
    ww = '1; ww[57] = 1'b0; ww[30] = 1'b0;
    do_write(4'd4, '1, ww);
    do_read(4'd4, r);
    checks++;
    if (r !== model[4]) begin errors++; $display("FAIL mask_slice1: got %h expected %h", r, model[4]); end
  endtask

  task automatic test_hold();
    logic [DW-1:0] r;
    do_write(4'd7, 59'h123, '0);
    do_read(4'd7, r);
    checks++;
    if (r !== 59'h123) begin errors++; $display("FAIL hold_read: got %h expected 123", r); end
    for (int i = 0; i < 5; i++) begin
      a = AW'($urandom); cen = 1'b1; gwen = 1'b0; d = rand_word();
      @(negedge clk);
      checks++;
      if (q !== 59'h123) begin errors++; $display("FAIL hold_cycle%0d: got %h expected 123", i, q); end
    end
    gwen = 1'b1;
  endtask

  task automatic test_latency();
    logic [DW-1:0] r;
    do_write(4'd5, 59'h3F, '0);
    do_read(4'd7, r);
    a = 4'd5; cen = 1'b0; gwen = 1'b1;
    #1;
    checks++;
    if (q !== 59'h123) begin errors++; $display("FAIL lat_before: got %h expected 123", q); end
    @(negedge clk);
    cen = 1'b1;
`ifdef CT_F_SPSRAM_OREG_EN
    checks++;
    if (q !== 59'h123) begin errors++; $display("FAIL lat_edge1: got %h expected 123", q); end
    @(negedge clk);
`endif
    checks++;
    if (q !== 59'h3F) begin errors++; $display("FAIL lat_valid: got %h expected 3f", q); end
  endtask

  task automatic test_busy_lockout();
    int n;
    logic [DW-1:0] r;
    pulse_reset();
    a = 4'd2; d = 59'hABC; wen = '0; cen = 1'b0; gwen = 1'b0;
    n = 0;
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    cen = 1'b1; gwen = 1'b1;
    checks++;
    if (n != DEPTH) begin errors++; $display("FAIL lockout_busy_len: got %0d expected %0d", n, DEPTH); end
    checks++;
    if (q !== '0) begin errors++; $display("FAIL lockout_q_idle: got %h expected 0", q); end
    do_read(4'd2, r);
    checks++;
    if (r !== '0) begin errors++; $display("FAIL lockout_addr2: got %h expected 0", r); end
  endtask

  task automatic test_mid_init_reset();
    int n;
    logic [DW-1:0] r;
    do_write(4'd12, rand_word(), '0);
    do_write(4'd15, rand_word(), '0);
    pulse_reset();
    repeat (9) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL midinit_busy: got %b expected 1", busy); end
    pulse_reset();
    wait_busy_low(n);
    checks++;
    if (n != DEPTH) begin errors++; $display("FAIL midinit_busy_len: got %0d expected %0d", n, DEPTH); end
    for (int i = 0; i < DEPTH; i++) begin
      do_read(AW'(i), r);
      checks++;
      if (r !== '0) begin errors++; $display("FAIL midinit_zero[%0d]: got %h expected 0", i, r); end
    end
  endtask

  task automatic test_random();
    logic [DW-1:0] r;
    logic [DW-1:0] e;
    logic [AW-1:0] ad;
    for (int k = 0; k < 80; k++) begin
      ad = AW'($urandom_range(0, DEPTH - 1));
      if ($urandom_range(0, 1) == 0) begin
        do_write(ad, rand_word(), rand_word());
      end else begin
        exp_q.push_back(model[ad]);
        do_read(ad, r);
        e = exp_q.pop_front();
        checks++;
        if (r !== e) begin errors++; $display("FAIL random_read[%0d] addr %0d: got %h expected %h", k, ad, r, e); end
      end
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_init_fill();
    test_slice_mask();
    test_hold();
    test_latency();
    test_busy_lockout();
    test_mid_init_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
